uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
Frame-sequencing controller for the UART transmitter. It accepts a transmit request and then steps the Tx output mux select through the start, data, optional parity and stop phases, one bit per CLK cycle. It also gates the serializer, emits a one-cycle load strobe toward the serializer and parity calculator, and reports busy to the upstream source. It sits between the Tx datapath (serializer, parity calc, output mux) and the request source.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; legal range 1..16.
CNT_WIDTH, 4, width of the internal data-bit counter; must satisfy 2^CNT_WIDTH >= DATA_WIDTH.

Ports:
CLK  input  1  Tx bit clock; one frame bit per cycle.
RST  input  1  synchronous, active-high reset.
Data_Valid  input  1  request to send a frame; sampled only in IDLE.
PAR_EN  input  1  parity-bit enable; captured at frame acceptance.
Mux_Sel  output  3  Tx mux select: 000 IDLE, 001 START, 010 DATA, 011 PARITY, 100 STOP.
Ser_En  output  1  serializer shift enable; high during DATA cycles only.
Data_Load  output  1  one-cycle strobe telling the serializer and parity calc to capture P_DATA.
Busy  output  1  frame in progress.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. RST=1 at any CLK edge forces the following, overriding every other input, including mid-frame:
  - state=IDLE, Mux_Sel=000, Ser_En=0, Busy=0, bit counter=0, latched parity enable=0, Data_Load=0.
- State register encoding equals Mux_Sel. Mux_Sel is driven directly from the state register, so it is glitch-free and registered.
- Busy = (state != IDLE). Ser_En = (state == DATA). Both decode from registered state.
- IDLE:
  - Data_Load = Data_Valid, combinational, same cycle. This is the accept cycle.
  - On acceptance: latch PAR_EN into par_en_q and go to START.
  - Otherwise stay in IDLE.
- START: exactly 1 cycle. Clear the counter, then go to DATA.
- DATA: lasts exactly DATA_WIDTH cycles.
  - The counter increments each cycle from 0.
  - When counter == DATA_WIDTH-1: go to PARITY if par_en_q=1, else go to STOP. The counter returns to 0.
- PARITY: 1 cycle, then STOP.
- STOP: 1 cycle, then IDLE.
- Frame timing:
  - Accept at cycle t. START occupies t+1. DATA occupies t+2 .. t+1+DATA_WIDTH.
  - Frame length is 2+DATA_WIDTH+par_en_q cycles. Busy is high for exactly that many cycles.
  - Earliest next accept is the first IDLE cycle after STOP. Minimum gap is 1 IDLE cycle (see optional feature).
- Data_Valid while Busy=1 is ignored: no queuing, no Data_Load.
- PAR_EN changes after acceptance do not affect the current frame.
- Data_Load is never asserted outside IDLE (or outside the STOP case under the optional feature).
- Illegal state encodings (101..111) transition to IDLE on the next edge with all outputs at reset values.

Optional Feature:
UART_TX_B2B_EN
- Defined: back-to-back frames are enabled.
  - In STOP, Data_Valid=1 asserts Data_Load in that cycle, latches PAR_EN, and moves the next state directly to START. No IDLE cycle is inserted.
  - Busy stays continuously high across frames.
- Undefined:
  - STOP always returns to IDLE.
  - Data_Valid in STOP is ignored.
  - At least one IDLE cycle (Busy=0, Mux_Sel=000) separates frames.

Test Plan:
1. Reset then idle: RST=1 for 2 cycles, Data_Valid=0 for 10 cycles -> Mux_Sel=000, Busy=0, Ser_En=0, Data_Load=0 on every cycle.
2. No-parity frame: DATA_WIDTH=8, PAR_EN=0, Data_Valid pulsed 1 cycle in IDLE -> Data_Load=1 that cycle. Then Mux_Sel sequence is 001, 010×8, 100, 000. Ser_En is high exactly 8 cycles. Busy is high exactly 10 cycles.
3. Parity frame: PAR_EN=1 at accept, then dropped to 0 during DATA -> sequence is 001, 010×8, 011, 100. Busy is high 11 cycles.
4. Request during busy: Data_Valid held 1 through an entire frame -> no Data_Load while Busy=1. Without UART_TX_B2B_EN: one IDLE cycle, then a new accept with Data_Load=1. With UART_TX_B2B_EN: Data_Load=1 in the STOP cycle and START follows immediately, with Busy never dropping.
5. Reset mid-frame: RST=1 while in DATA at counter=3 -> next cycle Mux_Sel=000, Busy=0, Ser_En=0. A subsequent request produces a full-length frame with the counter starting from 0.
6. Width corner: DATA_WIDTH=1, PAR_EN=1 -> sequence is 001, 010, 011, 100. Busy is high 4 cycles.

Source files
------------

// File: rtl/uart_tx_fsm_if.sv
// Handshake bundle between the UART Tx frame sequencer, its request source and the Tx datapath.
// The master side is the request source/datapath; the slave side is the sequencer.
interface uart_tx_fsm_if;
  logic       Data_Valid;
  logic       PAR_EN;
  logic [2:0] Mux_Sel;
  logic       Ser_En;
  logic       Data_Load;
  logic       Busy;

  modport master (
    output Data_Valid,
    output PAR_EN,
    input  Mux_Sel,
    input  Ser_En,
    input  Data_Load,
    input  Busy
  );

  modport slave (
    input  Data_Valid,
    input  PAR_EN,
    output Mux_Sel,
    output Ser_En,
    output Data_Load,
    output Busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART Tx frame sequencer: walks START, DATA, optional PARITY and STOP, one bit per clock.
// Define UART_TX_B2B_EN to allow a new frame to be accepted in the STOP cycle (no idle gap).
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  uart_tx_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_par_en;
  logic                 r_busy;
  logic                 r_ser_en;

  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic                 w_next_par_en;
  logic                 w_accept;

  // Next-state, counter and accept decode; state encoding doubles as the mux select.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_par_en = r_par_en;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          w_accept      = 1'b1;
          w_next_par_en = bus.PAR_EN;
          w_next_state  = ST_START;
        end else begin
          w_next_state  = ST_IDLE;
        end
      end
      ST_START: begin
        w_next_cnt   = {CNT_WIDTH{1'b0}};
        w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_next_cnt   = {CNT_WIDTH{1'b0}};
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end else begin
          w_next_cnt   = r_cnt + CNT_WIDTH'(1);
          w_next_state = ST_DATA;
        end
      end
      ST_PARITY: begin
        w_next_state = ST_STOP;
      end
      ST_STOP: begin
`ifdef UART_TX_B2B_EN
        if (bus.Data_Valid) begin
          w_accept      = 1'b1;
          w_next_par_en = bus.PAR_EN;
          w_next_state  = ST_START;
        end else begin
          w_next_state  = ST_IDLE;
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_next_cnt    = {CNT_WIDTH{1'b0}};
        w_next_par_en = 1'b0;
      end
    endcase
  end

  // State, counter, latched parity enable and registered status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_WIDTH{1'b0}};
      r_par_en <= 1'b0;
      r_busy   <= 1'b0;
      r_ser_en <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_par_en <= w_next_par_en;
      // Flags precomputed from next state so they match a decode of the state register.
      r_busy   <= (w_next_state != ST_IDLE);
      r_ser_en <= (w_next_state == ST_DATA);
    end
  end

  assign bus.Mux_Sel   = r_state;
  assign bus.Busy      = r_busy;
  assign bus.Ser_En    = r_ser_en;
  assign bus.Data_Load = w_accept & ~i_rst;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Randomized bench for uart_tx_fsm: two instances (8-bit and 1-bit frames) share stimulus and
// are compared each cycle against a queue of expected mux codes built from the frame rules.
module tb_uart_tx_fsm;
`ifdef UART_TX_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv  = 1'b0;
  logic pen = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fsm_if if8 ();
  uart_tx_fsm_if if1 ();

  assign if8.Data_Valid = dv;
  assign if8.PAR_EN     = pen;
  assign if1.Data_Valid = dv;
  assign if1.PAR_EN     = pen;

  uart_tx_fsm #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut8 (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
  uart_tx_fsm #(.DATA_WIDTH(1), .CNT_WIDTH(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));

  logic [5:0] a8, a1;
  assign a8 = {if8.Mux_Sel, if8.Busy, if8.Ser_En, if8.Data_Load};
  assign a1 = {if1.Mux_Sel, if1.Busy, if1.Ser_En, if1.Data_Load};

  logic [2:0] q8[$];
  logic [2:0] q1[$];
  logic [5:0] e8, e1;
  int passed = 0;
  int total  = 0;

  function automatic logic [5:0] expv(input int qsz, input logic [2:0] head, input logic d, input logic r);
    logic [2:0] m;
    m = (qsz > 0) ? head : 3'b000;
    return {m, (qsz > 0), (m == 3'b010), (~r & d & ((qsz == 0) || (B2B && qsz == 1)))};
  endfunction

  task automatic apply(input logic d, input logic p, input logic r);
    dv = d; pen = p; rst = r;
    #1;
    e8 = expv(q8.size(), (q8.size() > 0) ? q8[0] : 3'b000, d, r);
    e1 = expv(q1.size(), (q1.size() > 0) ? q1[0] : 3'b000, d, r);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q8.delete();
      q1.delete();
    end else begin
      if (q8.size() > 0) void'(q8.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (e8[0]) begin
        q8.push_back(3'b001);
        repeat (8) q8.push_back(3'b010);
        if (pen) q8.push_back(3'b011);
        q8.push_back(3'b100);
      end
      if (e1[0]) begin
        q1.push_back(3'b001);
        q1.push_back(3'b010);
        if (pen) q1.push_back(3'b011);
        q1.push_back(3'b100);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 11; i++) begin
      apply(1'b0, 1'b0, (i == 0));
      total++; if (a8 !== e8) $display("FAIL reset_w8 cyc%0d: got %b want %b", i, a8, e8); else passed++;
      total++; if (a1 !== e1) $display("FAIL reset_w1 cyc%0d: got %b want %b", i, a1, e1); else passed++;
      tick();
    end
  endtask

  task automatic test_frame(input logic p, input string nm);
    int b8 = 0, b1 = 0, s8 = 0;
    for (int i = 0; i < 14; i++) begin
      apply((i == 0), (i == 0) ? p : 1'b0, 1'b0);
      total++; if (a8 !== e8) $display("FAIL %s_w8 cyc%0d: got %b want %b", nm, i, a8, e8); else passed++;
      total++; if (a1 !== e1) $display("FAIL %s_w1 cyc%0d: got %b want %b", nm, i, a1, e1); else passed++;
      b8 += int'(if8.Busy); b1 += int'(if1.Busy); s8 += int'(if8.Ser_En);
      tick();
    end
    total++; if (b8 !== 10 + int'(p)) $display("FAIL %s_busy_w8: got %0d want %0d", nm, b8, 10 + int'(p)); else passed++;
    total++; if (b1 !== 3 + int'(p)) $display("FAIL %s_busy_w1: got %0d want %0d", nm, b1, 3 + int'(p)); else passed++;
    total++; if (s8 !== 8) $display("FAIL %s_ser_w8: got %0d want 8", nm, s8); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad_load = 0;
    for (int i = 0; i < 30; i++) begin
      apply(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      total++; if (a8 !== e8) $display("FAIL b2b_w8 cyc%0d: got %b want %b", i, a8, e8); else passed++;
      total++; if (a1 !== e1) $display("FAIL b2b_w1 cyc%0d: got %b want %b", i, a1, e1); else passed++;
      if (if8.Data_Load && if8.Busy && if8.Mux_Sel != 3'b100) bad_load++;
      tick();
    end
    total++; if (bad_load !== 0) $display("FAIL b2b_load_busy: got %0d want 0", bad_load); else passed++;
  endtask

  task automatic test_reset_mid();
    int s8 = 0;
    for (int i = 0; i < 7; i++) begin
      // Cycle 0 accepts; cycle 5 is the DATA cycle with counter 3.
      apply((i == 0), 1'b0, (i == 5));
      total++; if (a8 !== e8) $display("FAIL rstmid_w8 cyc%0d: got %b want %b", i, a8, e8); else passed++;
      total++; if (a1 !== e1) $display("FAIL rstmid_w1 cyc%0d: got %b want %b", i, a1, e1); else passed++;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      apply((i == 0), 1'b0, 1'b0);
      total++; if (a8 !== e8) $display("FAIL rstmid_refr_w8 cyc%0d: got %b want %b", i, a8, e8); else passed++;
      s8 += int'(if8.Ser_En);
      tick();
    end
    total++; if (s8 !== 8) $display("FAIL rstmid_ser_w8: got %0d want 8", s8); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 80) == 0));
      total++; if (a8 !== e8) $display("FAIL rand_w8 cyc%0d: got %b want %b", i, a8, e8); else passed++;
      total++; if (a1 !== e1) $display("FAIL rand_w1 cyc%0d: got %b want %b", i, a1, e1); else passed++;
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame(1'b0, "nopar");
    test_frame(1'b1, "par");
    test_back_to_back();
    apply(1'b0, 1'b0, 1'b0);
    repeat (14) tick();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
